// File: rtl/sig_force_pkg.sv
// Shared types and constants for the multi-channel force/release override unit.
package sig_force_pkg;

  typedef enum logic {PASS, FORCED} force_st_t;

  // A force length equal to this value holds the channel until an explicit release
  localparam int unsigned STICKY_LEN = '0;

endpackage

// File: rtl/force_chan.sv
// One override channel: registered pass-through unless a captured value is being forced.
module force_chan
  import sig_force_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             force_req,
  input  logic [WIDTH-1:0] force_val,
  input  logic [CNT_W-1:0] force_len,
  input  logic             release_req,
  output logic [WIDTH-1:0] dout,
  output logic             forced,
  output logic             released
);

  force_st_t        state, state_nxt;
  logic [WIDTH-1:0] hold, hold_nxt;
  logic [WIDTH-1:0] dout_q, dout_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             sticky, sticky_nxt;
  logic             released_q, released_nxt;
  logic             load;

  always_ff @(posedge clk) begin
    if (rst) state <= PASS;
    else     state <= state_nxt;
  end

  // Release wins over a same-cycle force; expiry only applies to timed forces
  always_comb begin
    state_nxt = state;
    if (release_req)
      state_nxt = PASS;
    else if (force_req)
      state_nxt = FORCED;
    else if (state == FORCED && !sticky && cnt == CNT_W'(1))
      state_nxt = PASS;
  end

  always_comb begin
    load         = force_req && !release_req;
    hold_nxt     = hold;
    cnt_nxt      = cnt;
    sticky_nxt   = sticky;
    if (load) begin
      hold_nxt   = force_val;
      cnt_nxt    = force_len;
      sticky_nxt = (force_len == CNT_W'(STICKY_LEN));
    end else if (state == FORCED && state_nxt == FORCED && !sticky) begin
      cnt_nxt    = cnt - CNT_W'(1);
    end
    dout_nxt     = (state_nxt == FORCED) ? hold_nxt : din;
    released_nxt = (state == FORCED) && (state_nxt == PASS);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold       <= '0;
      cnt        <= '0;
      sticky     <= 1'b0;
      dout_q     <= '0;
      released_q <= 1'b0;
    end else begin
      hold       <= hold_nxt;
      cnt        <= cnt_nxt;
      sticky     <= sticky_nxt;
      dout_q     <= dout_nxt;
      released_q <= released_nxt;
    end
  end

  assign dout     = dout_q;
  assign forced   = (state == FORCED);
  assign released = released_q;

endmodule

// File: rtl/sig_force_release.sv
// Multi-channel override unit: fans the shared force controls out to independent channels.
module sig_force_release
  import sig_force_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [CHANNELS-1:0]       force_req,
  input  logic [WIDTH-1:0]          force_val,
  input  logic [CNT_W-1:0]          force_len,
  input  logic [CHANNELS-1:0]       release_req,
  output logic [CHANNELS*WIDTH-1:0] dout,
  output logic [CHANNELS-1:0]       forced,
  output logic [CHANNELS-1:0]       released
);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    force_chan #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .din        (din[g*WIDTH +: WIDTH]),
      .force_req  (force_req[g]),
      .force_val  (force_val),
      .force_len  (force_len),
      .release_req(release_req[g]),
      .dout       (dout[g*WIDTH +: WIDTH]),
      .forced     (forced[g]),
      .released   (released[g])
    );
  end

endmodule

// File: tb/tb_sig_force_release.sv
// Self-checking bench for sig_force_release: directed scenarios plus random traffic vs a remaining-cycles model.
module tb_sig_force_release;

  localparam int WIDTH    = 4;
  localparam int CHANNELS = 4;
  localparam int CNT_W    = 8;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [CHANNELS*WIDTH-1:0] din = '0;
  logic [CHANNELS-1:0]       force_req = '0;
  logic [WIDTH-1:0]          force_val = '0;
  logic [CNT_W-1:0]          force_len = '0;
  logic [CHANNELS-1:0]       release_req = '0;
  logic [CHANNELS*WIDTH-1:0] dout;
  logic [CHANNELS-1:0]       forced;
  logic [CHANNELS-1:0]       released;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: rem = cycles of forcing still to show (-1 = sticky, 0 = pass-through)
  int                        rem [CHANNELS];
  logic [WIDTH-1:0]          hv  [CHANNELS];
  logic [CHANNELS*WIDTH-1:0] exp_dout;
  logic [CHANNELS-1:0]       exp_forced;
  logic [CHANNELS-1:0]       exp_rel;

  sig_force_release #(
    .WIDTH(WIDTH),
    .CHANNELS(CHANNELS),
    .CNT_W(CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .force_req  (force_req),
    .force_val  (force_val),
    .force_len  (force_len),
    .release_req(release_req),
    .dout       (dout),
    .forced     (forced),
    .released   (released)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < CHANNELS; i++) begin
      if (rst) begin
        rem[i] = 0;
        hv[i]  = '0;
        exp_rel[i] = 1'b0;
        exp_forced[i] = 1'b0;
        exp_dout[i*WIDTH +: WIDTH] = '0;
      end else begin
        exp_rel[i] = 1'b0;
        if (release_req[i]) begin
          if (rem[i] != 0) exp_rel[i] = 1'b1;
          rem[i] = 0;
        end else if (force_req[i]) begin
          rem[i] = (force_len == 0) ? -1 : int'(force_len);
          hv[i]  = force_val;
        end else if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) exp_rel[i] = 1'b1;
        end
        exp_forced[i] = (rem[i] != 0);
        exp_dout[i*WIDTH +: WIDTH] = (rem[i] != 0) ? hv[i] : din[i*WIDTH +: WIDTH];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] vals [4];
    vals = '{4'd2, 4'd4, 4'd6, 4'd8};
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (dout !== '0 || forced !== '0 || released !== '0) begin
        n_fail++;
        $display("[TB] FAIL reset_state: dout=%h forced=%b released=%b, want all zero", dout, forced, released);
      end
    end
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      din[3:0] = vals[c];
      tick();
      n_cmp++;
      if (dout[3:0] !== vals[c] || forced !== '0) begin
        n_fail++;
        $display("[TB] FAIL pass_through: dout0=%0d forced=%b, want %0d / 0", dout[3:0], forced, vals[c]);
      end
      n_cmp++;
      if (dout !== exp_dout) begin
        n_fail++;
        $display("[TB] FAIL pass_model: dout=%h want %h", dout, exp_dout);
      end
    end
  endtask

  task automatic test_timed_force();
    int pulses = 0;
    for (int c = 0; c < 20; c++) begin
      din = {$urandom_range(0, 15)} << 4;
      din[15:4] = 12'($urandom);
      din[3:0] = 4'(2 + 2 * (c % 6));
      force_req = (c == 8) ? 4'b0001 : 4'b0000;
      force_val = 4'd14;
      force_len = 8'd9;
      tick();
      force_req = '0;
      if (released[0]) pulses++;
      if (c >= 8 && c <= 16) begin
        n_cmp++;
        if (dout[3:0] !== 4'd14 || forced[0] !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL timed_hold c=%0d: dout0=%0d forced0=%b, want 14 / 1", c, dout[3:0], forced[0]);
        end
      end
      if (c == 17) begin
        n_cmp++;
        if (released[0] !== 1'b1 || forced[0] !== 1'b0 || dout[3:0] !== din[3:0]) begin
          n_fail++;
          $display("[TB] FAIL timed_expire: rel0=%b forced0=%b dout0=%0d, want 1 / 0 / %0d", released[0], forced[0], dout[3:0], din[3:0]);
        end
      end
      n_cmp++;
      if (dout !== exp_dout || forced !== exp_forced || released !== exp_rel) begin
        n_fail++;
        $display("[TB] FAIL timed_model c=%0d: dout=%h/%b/%b want %h/%b/%b", c, dout, forced, released, exp_dout, exp_forced, exp_rel);
      end
    end
    n_cmp++;
    if (pulses != 1) begin
      n_fail++;
      $display("[TB] FAIL timed_pulse_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_sticky_release();
    force_req = 4'b0100;
    force_val = 4'd5;
    force_len = 8'd0;
    for (int c = 0; c < 21; c++) begin
      din = 16'($urandom);
      tick();
      force_req = '0;
      release_req = (c == 19) ? 4'b0100 : 4'b0000;
      if (c < 20) begin
        n_cmp++;
        if (dout[11:8] !== 4'd5 || forced[2] !== 1'b1 || released[2] !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL sticky_hold c=%0d: dout2=%0d forced2=%b rel2=%b, want 5 / 1 / 0", c, dout[11:8], forced[2], released[2]);
        end
      end else begin
        n_cmp++;
        if (dout[11:8] !== din[11:8] || forced[2] !== 1'b0 || released[2] !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL sticky_release: dout2=%0d forced2=%b rel2=%b, want %0d / 0 / 1", dout[11:8], forced[2], released[2], din[11:8]);
        end
      end
      n_cmp++;
      if (dout !== exp_dout || forced !== exp_forced || released !== exp_rel) begin
        n_fail++;
        $display("[TB] FAIL sticky_model c=%0d: dout=%h/%b/%b want %h/%b/%b", c, dout, forced, released, exp_dout, exp_forced, exp_rel);
      end
    end
    release_req = '0;
    tick();
  endtask

  task automatic test_simultaneous();
    force_req   = 4'b0010;
    release_req = 4'b0010;
    force_val   = 4'd7;
    force_len   = 8'd3;
    din         = 16'h3333;
    tick();
    force_req   = '0;
    release_req = '0;
    n_cmp++;
    if (forced[1] !== 1'b0 || released[1] !== 1'b0 || dout[7:4] !== 4'd3) begin
      n_fail++;
      $display("[TB] FAIL simul_req: forced1=%b rel1=%b dout1=%0d, want 0 / 0 / 3", forced[1], released[1], dout[7:4]);
    end
    tick();
    n_cmp++;
    if (forced[1] !== 1'b0 || released[1] !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL simul_after: forced1=%b rel1=%b, want 0 / 0", forced[1], released[1]);
    end
  endtask

  task automatic test_retrigger();
    logic [WIDTH-1:0] exp_seq [7];
    logic             exp_f   [7];
    exp_seq = '{4'd3, 4'd3, 4'd9, 4'd9, 4'd9, 4'd9, 4'd0};
    exp_f   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    din = '0;
    for (int c = 0; c < 7; c++) begin
      force_req = (c == 0 || c == 2) ? 4'b1000 : 4'b0000;
      force_val = (c == 0) ? 4'd3 : 4'd9;
      force_len = 8'd4;
      tick();
      n_cmp++;
      if (dout[15:12] !== exp_seq[c] || forced[3] !== exp_f[c]) begin
        n_fail++;
        $display("[TB] FAIL retrigger c=%0d: dout3=%0d forced3=%b, want %0d / %b", c, dout[15:12], forced[3], exp_seq[c], exp_f[c]);
      end
    end
    force_req = '0;
    n_cmp++;
    if (released[3] !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL retrigger_pulse: rel3=%b want 1", released[3]);
    end
  endtask

  task automatic test_reset_mid();
    force_req = 4'b0001;
    force_val = 4'd11;
    force_len = 8'd10;
    din = 16'hA5A5;
    for (int c = 0; c < 3; c++) begin
      tick();
      force_req = '0;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (dout !== '0 || forced !== '0 || released !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid: dout=%h forced=%b rel=%b, want all zero", dout, forced, released);
    end
    tick();
    n_cmp++;
    if (released !== '0 || forced !== '0 || dout !== 16'hA5A5) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_after: dout=%h forced=%b rel=%b, want a5a5 / 0 / 0", dout, forced, released);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      din = 16'($urandom);
      for (int i = 0; i < CHANNELS; i++) begin
        force_req[i]   = ($urandom_range(0, 9) == 0);
        release_req[i] = ($urandom_range(0, 19) == 0);
      end
      force_val = 4'($urandom);
      force_len = 8'($urandom_range(0, 6));
      tick();
      n_cmp++;
      if (dout !== exp_dout || forced !== exp_forced || released !== exp_rel) begin
        n_fail++;
        $display("[TB] FAIL random c=%0d: dout=%h/%b/%b want %h/%b/%b", c, dout, forced, released, exp_dout, exp_forced, exp_rel);
      end
    end
    rst = 1'b0;
    force_req = '0;
    release_req = '0;
  endtask

  initial begin
    test_reset();
    test_timed_force();
    test_sticky_release();
    test_simultaneous();
    test_retrigger();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sig_force_release.md
# sig_force_release

Parametrised, synthesizable multi-channel override unit: each channel passes its input through a register unless a force request substitutes a captured constant for a programmed number of cycles, or until an explicit release. This is the hardware counterpart of procedural force/release on continuously-assigned nets. It sits between a data source and its consumers, and is used for fault injection and debug pinning of buses.

## Interface
- `WIDTH`, 4, bits per channel
- `CHANNELS`, 4, independent channels
- `CNT_W`, 8, width of the force-duration counter
- `clk` input 1 — single clock, rising edge
- `rst` input 1 — synchronous, active-high reset
- `din` input CHANNELS*WIDTH — live data; channel i at [i*WIDTH +: WIDTH]
- `force_req` input CHANNELS — per-channel single-cycle force request
- `force_val` input WIDTH — value captured by every channel whose `force_req` is high
- `force_len` input CNT_W — duration in cycles; 0 = sticky (held until release)
- `release_req` input CHANNELS — per-channel release request
- `dout` output CHANNELS*WIDTH — registered output
- `forced` output CHANNELS — per-channel: channel currently driving its forced value
- `released` output CHANNELS — one-cycle pulse on the first cycle a channel returns to pass-through

## Operation
- Per-channel FSM with two states, PASS and FORCED; reset state is PASS.
- PASS -> FORCED: `force_req[i]`=1 and `release_req[i]`=0. On this transition, capture `force_val` into `hold[i]`, load `cnt[i]`=`force_len`, and set `sticky[i]`=(`force_len`==0).
- FORCED -> FORCED (retrigger): `force_req[i]`=1 and `release_req[i]`=0. Recapture the value and reload the count.
- FORCED -> PASS, on any of:
  - `release_req[i]`=1
  - non-sticky and `cnt[i]`==1 with no retrigger
- `release_req[i]` has priority over `force_req[i]` in the same cycle.
- `release_req` while in PASS: ignored, no pulse.
- Counter: decrements by 1 each FORCED cycle when non-sticky; holds when sticky. Never wraps; 0 is reached only in sticky mode.
- Data path, per cycle: `dout[i]` <= `hold[i]` if the next state is FORCED, else `din[i]`.
- Channels are fully independent; any mix of channels may be forced at once.
- `force_val` and `force_len` are shared: channels requested in the same cycle get identical values.

## Timing
- Reset values: `dout`=0, `forced`=0, `released`=0, all `cnt`=0, all `hold`=0, all FSMs in PASS.
- Pass-through latency: 1 cycle; `din` sampled at edge N appears on `dout` after edge N.
- Force request sampled at edge N (non-sticky, length L):
  - `dout[i]`=`force_val` and `forced[i]`=1 for exactly L cycles, following edges N..N+L-1.
  - After edge N+L, `dout[i]` shows `din` sampled at N+L, `forced[i]`=0, and `released[i]`=1 for that one cycle.
- Release sampled at edge M: `dout` reflects `din` after edge M, with `released` pulsing in the same cycle.
- Retrigger at edge R: the remaining duration becomes `force_len` (sampled at R), counted from R.
- `rst` mid-force: all channels return to PASS after the reset edge, with no `released` pulse.

## Structure
- Package `sig_force_pkg`: `typedef enum logic {PASS, FORCED} force_st_t`; localparam `STICKY_LEN` = '0.
- Natural sub-module: `force_chan`, one channel (FSM, counter, hold register, output mux).
  - Top instantiates `CHANNELS` copies in a generate loop and fans out the shared inputs.

## Test plan
- Reset and pass-through:
  - Stimulus: hold `rst` 2 cycles, then drive ch0 `din` 2,4,6,8 on successive cycles.
  - Required response: `dout` all zeros during reset, then ch0 shows 2,4,6,8 each one cycle later; `forced`=0 throughout.
- Timed force:
  - Stimulus: ch0 `din` stepping 2..12; at cycle 8 pulse `force_req[0]` with `force_val`=14, `force_len`=9.
  - Required response: ch0 `dout`=14 for 9 cycles, then the live `din` value; `released[0]` pulses once; ch1-3 unaffected.
- Sticky plus release:
  - Stimulus: `force_len`=0, `force_val`=5 on ch2; 20 cycles later pulse `release_req[2]`.
  - Required response: `dout[2]`=5 for all 20 cycles; pass-through resumes the cycle after release.
- Simultaneous events:
  - Stimulus: same cycle, `force_req[1]` and `release_req[1]` while ch1 is in PASS.
  - Required response: ch1 stays in PASS with no pulse.
  - Stimulus: ch3 forced with L=4, retriggered at its 3rd cycle with L=4, `force_val`=9.
  - Required response: 2 cycles of the old value, then 4 cycles of 9.
- Reset mid-force:
  - Stimulus: assert `rst` during a ch0 force of L=10.
  - Required response: `dout`=0 and `forced`=0 after the edge; `released` stays 0.
